// File: rtl/tcb_gpio_pkg.sv
// rtl/tcb_gpio_pkg.sv - register map and synchronizer limits for the TCB GPIO block
package tcb_gpio_pkg;

  // Register index as decoded from adr[5:2]
  typedef enum logic [3:0] {
    REG_OUT      = 4'd0,
    REG_OE       = 4'd1,
    REG_IN       = 4'd2,
    REG_OUT_SET  = 4'd3,
    REG_OUT_CLR  = 4'd4,
    REG_IRQ_EN   = 4'd5,
    REG_IRQ_RISE = 4'd6,
    REG_IRQ_FALL = 4'd7,
    REG_IRQ_STA  = 4'd8
  } reg_e;

  localparam int CDC_MIN = 0;
  localparam int CDC_MAX = 4;

  function automatic logic reg_mapped(input logic [3:0] idx);
    return idx <= 4'(REG_IRQ_STA);
  endfunction

endpackage

// File: rtl/tcb_if.sv
// rtl/tcb_if.sv - TCB bus interface with manager/subordinate modports
interface tcb_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int DLY = 1
) ();

  logic            vld;
  logic            wen;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] ben;
  logic [DW-1:0]   wdt;
  logic [DW-1:0]   rdt;
  logic            rdy;
  logic            err;

  modport man (output vld, wen, adr, ben, wdt, input rdt, rdy, err);
  modport sub (input vld, wen, adr, ben, wdt, output rdt, rdy, err);

endinterface

// File: rtl/tcb_gpio_cdc.sv
// rtl/tcb_gpio_cdc.sv - multi-flop input synchronizer, depth 0 is a straight wire
module tcb_gpio_cdc #(
  parameter int GW      = 32,
  parameter int CFG_CDC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] d_i,
  output logic [GW-1:0] q_o
);

  if (CFG_CDC == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_sync
    logic [CFG_CDC-1:0][GW-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int i = 1; i < CFG_CDC; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign q_o = sync_q[CFG_CDC-1];
  end

endmodule

// File: rtl/tcb_gpio_irq.sv
// rtl/tcb_gpio_irq.sv - GPIO register block with edge-triggered interrupt status on a TCB subordinate port
module tcb_gpio_irq
  import tcb_gpio_pkg::*;
#(
  parameter int GW      = 32,
  parameter int CFG_CDC = 2,
  parameter int DLY     = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [GW-1:0] gpio_o,
  output logic [GW-1:0] gpio_e,
  input  logic [GW-1:0] gpio_i,
  output logic          irq,
  tcb_if.sub            bus
);

  localparam int DW = bus.DW;

  if (GW < 1 || GW > DW) begin : g_bad_gw
    $error("tcb_gpio_irq: GW out of range 1..DW");
  end
  if (CFG_CDC < CDC_MIN || CFG_CDC > CDC_MAX) begin : g_bad_cdc
    $error("tcb_gpio_irq: CFG_CDC out of range");
  end
  if (DLY != bus.DLY || DLY != 1) begin : g_bad_dly
    $error("tcb_gpio_irq: DLY must be 1 and match bus.DLY");
  end

  logic [GW-1:0] out_q, out_d, oe_q, oe_d;
  logic [GW-1:0] ien_q, ien_d, irise_q, irise_d, ifall_q, ifall_d;
  logic [GW-1:0] sta_q, sta_d, prev_q, sync;
  logic [DW-1:0] rdt_q, rdt_d, rd, bmask;
  logic          irq_q, irq_d;

  tcb_gpio_cdc #(.GW(GW), .CFG_CDC(CFG_CDC)) u_cdc (
    .clk (clk),
    .rst (rst),
    .d_i (gpio_i),
    .q_o (sync)
  );

  for (genvar b = 0; b < DW/8; b++) begin : g_ben
    assign bmask[8*b +: 8] = {8{bus.ben[b]}};
  end

  logic          xfer, wr, mapped, unused;
  logic [GW-1:0] m, wd, ev, sta_clr;
  reg_e          idx;

  assign idx    = reg_e'(bus.adr[5:2]);
  assign mapped = reg_mapped(bus.adr[5:2]);
  assign xfer   = bus.vld & bus.rdy;
  assign wr     = xfer & bus.wen;
  assign m      = bmask[GW-1:0];
  assign wd     = bus.wdt[GW-1:0] & m;
  assign unused = ^{bus.adr, bus.wdt, bmask};

  assign bus.rdy = 1'b1;
  assign bus.err = bus.vld & ~mapped;
  assign bus.rdt = rdt_q;
  assign gpio_o  = out_q;
  assign gpio_e  = oe_q;
  assign irq     = irq_q;

  // Events use the synchronized value against its one-cycle-old copy
  assign ev = ((sync & ~prev_q) & irise_q) | ((~sync & prev_q) & ifall_q);

  always_comb begin
    out_d   = out_q;
    oe_d    = oe_q;
    ien_d   = ien_q;
    irise_d = irise_q;
    ifall_d = ifall_q;
    sta_clr = '0;
    if (wr) begin
      case (idx)
        REG_OUT:      out_d   = (out_q & ~m) | wd;
        REG_OE:       oe_d    = (oe_q & ~m) | wd;
        REG_OUT_SET:  out_d   = out_q | wd;
        REG_OUT_CLR:  out_d   = out_q & ~wd;
        REG_IRQ_EN:   ien_d   = (ien_q & ~m) | wd;
        REG_IRQ_RISE: irise_d = (irise_q & ~m) | wd;
        REG_IRQ_FALL: ifall_d = (ifall_q & ~m) | wd;
        REG_IRQ_STA:  sta_clr = wd;
        default:      ;
      endcase
    end
    // A fresh event outranks a simultaneous clear
    sta_d = (sta_q & ~sta_clr) | ev;
    irq_d = |(sta_q & ien_q);

    rd = '0;
    case (idx)
      REG_OUT:      rd = DW'(out_q);
      REG_OE:       rd = DW'(oe_q);
      REG_IN:       rd = DW'(sync);
      REG_IRQ_EN:   rd = DW'(ien_q);
      REG_IRQ_RISE: rd = DW'(irise_q);
      REG_IRQ_FALL: rd = DW'(ifall_q);
      REG_IRQ_STA:  rd = DW'(sta_q);
      default:      rd = '0;
    endcase
    rdt_d = (xfer && !bus.wen) ? rd : rdt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      oe_q    <= '0;
      ien_q   <= '0;
      irise_q <= '0;
      ifall_q <= '0;
      sta_q   <= '0;
      prev_q  <= '0;
      rdt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      ien_q   <= ien_d;
      irise_q <= irise_d;
      ifall_q <= ifall_d;
      sta_q   <= sta_d;
      prev_q  <= sync;
      rdt_q   <= rdt_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_tcb_gpio_irq.sv
// tb/tb_tcb_gpio_irq.sv - directed vector bench for tcb_gpio_irq
module tb_tcb_gpio_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gpio_o, gpio_e, gpio_i;
  logic        irq;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  tcb_if #(.AW(32), .DW(32), .DLY(1)) bus ();

  tcb_gpio_irq #(.GW(32), .CFG_CDC(2), .DLY(1)) dut (
    .clk    (clk),
    .rst    (rst_n),
    .gpio_o (gpio_o),
    .gpio_e (gpio_e),
    .gpio_i (gpio_i),
    .irq    (irq),
    .bus    (bus)
  );

  typedef struct {
    logic        wen;
    logic [7:0]  adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic        err;
    logic [31:0] rdt;
    logic [31:0] out;
    logic [31:0] oe;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic wen, input logic [31:0] adr, input logic [3:0] ben,
                      input logic [31:0] wdt, output logic err);
    @(negedge clk);
    bus.vld = 1'b1;
    bus.wen = wen;
    bus.adr = adr;
    bus.ben = ben;
    bus.wdt = wdt;
    #1 err = bus.err;
    @(posedge clk);
    #1;
    bus.vld = 1'b0;
    bus.wen = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wdt);
    logic e;
    xfer(1'b1, adr, 4'hF, wdt, e);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic e;
    xfer(1'b0, adr, 4'hF, 32'h0, e);
    chk(name, bus.rdt, exp);
  endtask

  initial begin
    logic        e;
    logic [31:0] hold;

    bus.vld = 1'b0; bus.wen = 1'b0; bus.adr = '0; bus.ben = '0; bus.wdt = '0;
    gpio_i  = '0;

    //                 wen   adr    ben   wdt            err   rdt            out            oe
    vecs.push_back('{1'b1, 8'h00, 4'h5, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h00FF00FF, 32'h0});
    vecs.push_back('{1'b1, 8'h00, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0,        32'hA5A5A5A5, 32'h0});
    vecs.push_back('{1'b1, 8'h04, 4'hF, 32'hFFFF0000, 1'b0, 32'h0,        32'hA5A5A5A5, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h00, 4'hF, 32'h0,        1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h04, 4'hF, 32'h0,        1'b0, 32'hFFFF0000, 32'hA5A5A5A5, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h00, 4'hF, 32'h000000F0, 1'b0, 32'h0,        32'h000000F0, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h0C, 4'hF, 32'h0000000F, 1'b0, 32'h0,        32'h000000FF, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h10, 4'hF, 32'h00000030, 1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h0C, 4'hF, 32'h0,        1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h10, 4'hF, 32'h0,        1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h00, 4'hF, 32'h0,        1'b0, 32'h000000CF, 32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h08, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h08, 4'hF, 32'h0,        1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h24, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h24, 4'hF, 32'h0,        1'b1, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h14, 4'h3, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h14, 4'hF, 32'h0,        1'b0, 32'h0000FFFF, 32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h00, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h20, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h20, 4'hF, 32'h0,        1'b0, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b0, 8'h3C, 4'hF, 32'h0,        1'b1, 32'h0,        32'h000000CF, 32'hFFFF0000});
    vecs.push_back('{1'b1, 8'h04, 4'h2, 32'h00001234, 1'b0, 32'h0,        32'h000000CF, 32'hFFFF1200});
    vecs.push_back('{1'b0, 8'h04, 4'hF, 32'h0,        1'b0, 32'hFFFF1200, 32'h000000CF, 32'hFFFF1200});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_gpio_o", gpio_o, 32'h0);
    chk("reset_gpio_e", gpio_e, 32'h0);
    chk("reset_rdt", bus.rdt, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("rdy_const", {31'h0, bus.rdy}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    hold = 32'h0;
    foreach (vecs[i]) begin
      xfer(vecs[i].wen, {24'h0, vecs[i].adr}, vecs[i].ben, vecs[i].wdt, e);
      if (!vecs[i].wen) hold = vecs[i].rdt;
      chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].err});
      chk($sformatf("vec%0d_rdt", i), bus.rdt, hold);
      chk($sformatf("vec%0d_out", i), gpio_o, vecs[i].out);
      chk($sformatf("vec%0d_oe", i), gpio_e, vecs[i].oe);
    end

    // Rising edge on bit 3: status after CDC+1 clocks, irq after CDC+2
    wr(32'h14, 32'h8);
    wr(32'h18, 32'h8);
    wr(32'h1C, 32'h0);
    @(negedge clk);
    gpio_i = 32'h8;
    repeat (3) @(posedge clk);
    #1 chk("irq_before_4clk", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("irq_at_4clk", {31'h0, irq}, 32'h1);
    rd_chk("sta_rise3", 32'h20, 32'h8);

    // Falling edge on bit 3 is not enabled as an event
    @(negedge clk);
    gpio_i = 32'h0;
    repeat (6) @(posedge clk);
    rd_chk("sta_no_fall", 32'h20, 32'h8);

    // Clear collides with a new rise on bit 3: the event wins
    @(negedge clk);
    gpio_i = 32'h8;
    @(posedge clk);
    @(posedge clk);
    wr(32'h20, 32'h8);
    chk("irq_collide", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1 chk("irq_collide_next", {31'h0, irq}, 32'h1);
    rd_chk("sta_collide", 32'h20, 32'h8);

    // Plain clear with no event drops status, then irq one clock later
    wr(32'h20, 32'h8);
    chk("irq_clr_same", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1 chk("irq_cleared", {31'h0, irq}, 32'h0);
    rd_chk("sta_cleared", 32'h20, 32'h0);

    // Fall event on bit 0 with IRQ_EN off, then enabling raises irq
    wr(32'h1C, 32'h1);
    @(negedge clk);
    gpio_i = 32'h9;
    repeat (5) @(posedge clk);
    @(negedge clk);
    gpio_i = 32'h8;
    repeat (5) @(posedge clk);
    rd_chk("sta_fall0", 32'h20, 32'h1);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr(32'h14, 32'h9);
    chk("irq_en_same", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("irq_en_next", {31'h0, irq}, 32'h1);
    rd_chk("in_read", 32'h08, 32'h8);

    // Asynchronous reset mid-cycle with irq high and nonzero outputs
    wr(32'h00, 32'h12345678);
    wr(32'h04, 32'h000000FF);
    rd_chk("out_pre_rst", 32'h00, 32'h12345678);
    @(negedge clk);
    gpio_i = 32'hFFFFFFFF;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_irq", {31'h0, irq}, 32'h0);
    chk("arst_gpio_o", gpio_o, 32'h0);
    chk("arst_gpio_e", gpio_e, 32'h0);
    chk("arst_rdt", bus.rdt, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("post_rst_irq", {31'h0, irq}, 32'h0);
    rd_chk("post_rst_sta", 32'h20, 32'h0);
    rd_chk("post_rst_in", 32'h08, 32'hFFFFFFFF);
    rd_chk("post_rst_rise", 32'h18, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcb_gpio_irq.md
TCB_GPIO_IRQ -- requirements
Module: tcb_gpio_irq

Interface
REQ-001 Parameter GW, default 32: GPIO width, legal 1..bus.DW.
REQ-002 Parameter CFG_CDC, default 2: input synchronizer depth; 0 means bypass, legal 0..4.
REQ-003 Parameter DLY, default 1: read data delay; SHALL equal bus.DW-side bus.DLY, else elaboration $error.
REQ-004 clk  input  1  single clock for all logic; bus.clk SHALL be the same net.
REQ-005 rst  input  1  asynchronous, active-low reset; bus.rst unused.
REQ-006 gpio_o  output  GW  output data.
REQ-007 gpio_e  output  GW  output enable.
REQ-008 gpio_i  input  GW  asynchronous input pins.
REQ-009 irq  output  1  level interrupt request.
REQ-010 bus  tcb_if.sub  -  TCB subordinate: vld, wen, adr, ben, wdt, rdt, rdy, err.

Function
REQ-011 Register map, decoded on adr[5:2], offsets: 0x00 OUT rw, 0x04 OE rw, 0x08 IN ro, 0x0C OUT_SET w1s, 0x10 OUT_CLR w1c, 0x14 IRQ_EN rw, 0x18 IRQ_RISE rw, 0x1C IRQ_FALL rw, 0x20 IRQ_STA r/w1c.
REQ-012 Transfer occurs when bus.vld & bus.rdy; bus.rdy SHALL be constant 1.
REQ-013 Read data SHALL appear on bus.rdt exactly 1 clk after the transfer and hold until the next read transfer.
REQ-014 Reads of OUT_SET, OUT_CLR and unmapped offsets SHALL return 0; bits GW..DW-1 SHALL read 0.
REQ-015 bus.err SHALL be 1 for a transfer to an unmapped offset and 0 otherwise, combinational with the request.
REQ-016 Writes SHALL honor bus.ben per byte; bytes with ben=0 leave register bits unchanged.
REQ-017 OUT_SET write: gpio_o |= wdt; OUT_CLR write: gpio_o &= ~wdt; effect visible 1 clk after transfer.
REQ-018 IN SHALL return gpio_i after CFG_CDC flops (CFG_CDC=0: direct combinational sample).
REQ-019 Edge detect: rise[i] = sync[i] & ~prev[i]; fall[i] = ~sync[i] & prev[i]; prev is sync delayed 1 clk.
REQ-020 IRQ_STA[i] SHALL set when (rise[i] & IRQ_RISE[i]) | (fall[i] & IRQ_FALL[i]), independent of IRQ_EN.
REQ-021 IRQ_STA write clears bits where wdt=1 (per enabled byte); same-cycle new event on a bit SHALL win (bit stays 1).
REQ-022 irq SHALL be registered: irq = |(IRQ_STA & IRQ_EN), 1 clk after status/enable change.
REQ-023 Total pin-edge-to-irq latency SHALL be CFG_CDC + 2 clk cycles.
REQ-024 Writes to IN, read-only bits and unmapped offsets SHALL have no effect.

Reset
REQ-025 While rst=0: gpio_o, gpio_e, bus.rdt, irq, all registers, sync chain and prev SHALL be 0.
REQ-026 Reset mid-transfer SHALL abort it; no register update, rdt 0.
REQ-027 After rst release, no edge event SHALL be recorded before IRQ_RISE/IRQ_FALL are written (both reset to 0).

Structure
REQ-028 Package tcb_gpio_pkg SHALL hold the register offset enum and CFG_CDC limits.
REQ-029 Sub-module tcb_gpio_cdc (parametrised GW, CFG_CDC, reset to 0) SHALL implement the synchronizer.
REQ-030 Edge detection, status and bus decode SHALL live in tcb_gpio_irq; no latches, no combinational path gpio_i->irq.

Verification
REQ-031 Write OUT=0xA5A5_A5A5, OE=0xFFFF_0000, read both -> rdt 0xA5A5_A5A5 then 0xFFFF_0000, each 1 clk after request.
REQ-032 OUT=0x0000_00F0, OUT_SET=0x0F, OUT_CLR=0x30 -> gpio_o=0x0000_00CF; reads of OUT_SET return 0.
REQ-033 CFG_CDC=2, IRQ_RISE[3]=1, IRQ_EN[3]=1, gpio_i[3] 0->1 -> IRQ_STA=0x8 and irq=1 exactly 4 clk after pin edge.
REQ-034 W1C IRQ_STA=0x8 in the same cycle as a new rise on bit 3 -> IRQ_STA stays 0x8, irq stays 1.
REQ-035 Write OUT=0xFFFF_FFFF with ben=0b0101 from reset -> gpio_o=0x00FF_00FF; access to offset 0x24 -> err=1, no state change.
REQ-036 Assert rst=0 asynchronously mid-cycle with irq=1 -> irq, gpio_o, gpio_e, rdt 0 immediately; no event after release with gpio_i held high.
